rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

Reorder buffer for the out-of-order core, sitting between decoder/issue, the reservation stations and load/store buffer, and the register file. It allocates a ROB entry per issued instruction and supplies the register file's rename update (`new_reg_id`/`new_ROB_id`). It collects results from the two result buses, answers operand-readiness queries from the register file, and retires entries in program order: register writes, store release, and branch mispredict recovery via `clear_flag`.

## Interface
- ROB_WIDTH_BIT, 3, index width; depth = 2^ROB_WIDTH_BIT entries
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  pause when low: no state change, commit outputs forced 0
- issue_valid  input  1  decoder issues one instruction this cycle
- issue_type  input  2  0=REG (writes rd), 1=STORE, 2=BRANCH, 3=EXIT
- issue_rd  input  5  destination register (REG only)
- issue_pred_taken  input  1  predicted direction (BRANCH)
- issue_alt_pc  input  32  recovery PC if prediction wrong
- rob_full  output  1  no free entry; decoder must not issue
- issue_rob_id  output  ROB_WIDTH_BIT  tail index given to the issuing instruction
- new_reg_id  output  5  to regfile: issue_rd when issue accepted and type REG, else 0
- new_ROB_id  output  ROB_WIDTH_BIT  to regfile: tail index
- alu_cdb_valid / alu_cdb_id / alu_cdb_val  input  1 / ROB_WIDTH_BIT / 32  ALU result bus; for BRANCH, val[0] = actual taken
- lsb_cdb_valid / lsb_cdb_id / lsb_cdb_val  input  1 / ROB_WIDTH_BIT / 32  load/store result bus
- rs1_id, rs2_id  input  ROB_WIDTH_BIT  regfile dependency queries
- rs1_ready, rs2_ready  output  1  queried entry has a result
- rs1_val, rs2_val  output  32  queried entry's result
- write_reg_id  output  5  commit: destination register, 0 = no write
- write_ROB_id  output  ROB_WIDTH_BIT  commit: head index
- write_val  output  32  commit: result
- store_commit  output  1  head STORE retires; LSB may perform it
- store_commit_id  output  ROB_WIDTH_BIT  ROB index of that store
- clear_flag  output  1  one-cycle flush pulse to all units
- redirect_pc  output  32  fetch target, valid while clear_flag
- halt  output  1  EXIT committed; sticky until reset

## Operation
- Entry fields: busy, ready, type, rd, value, pred_taken, alt_pc. Pointers head and tail are ROB_WIDTH_BIT wide and wrap modulo depth; count is ROB_WIDTH_BIT+1 wide.
- Issue is accepted when issue_valid && !rob_full && !clear_flag && rdy_in && !halt. On acceptance the tail entry is written with busy=1, ready=0, and tail and count are incremented.
- new_reg_id and new_ROB_id are combinational from the issue inputs in the same cycle, so the regfile renames on the same edge. new_reg_id=0 when issue is not accepted.
- CDB: on each valid bus, set entry[id].ready=1 and value=val. Both buses may write in one cycle to different ids. The same id on both buses is illegal.
- Query: rsN_ready/rsN_val come from entry[rsN_id]. A same-cycle CDB match bypasses the entry (ALU has priority), giving ready=1 and the bus value.
- Commit: when head is busy && ready && rdy_in && !clear_flag, at most one entry retires per cycle. Head is cleared and head advances.
  - REG: write_reg_id=rd, write_ROB_id=head, write_val=value. All three are combinational and asserted for the commit cycle only.
  - STORE: store_commit=1, store_commit_id=head.
  - BRANCH: if value[0]==pred_taken, retire silently. Otherwise flush: at the edge, head=tail=count=0 and all busy=0. clear_flag=1 and redirect_pc=alt_pc are registered for exactly the next cycle.
  - EXIT: set halt=1. Further issue and commit are blocked.
- During the clear_flag cycle, issue and commit are suppressed and CDB writes are ignored.
- Simultaneous issue and commit: count is unchanged. rob_full is computed from registered count only, so a commit does not free a slot in the same cycle.

## Timing
- Reset: all entries not busy; head=tail=count=0; rob_full=0, clear_flag=0, redirect_pc=0, halt=0, store_commit=0, write_reg_id=0.
- Reset applied mid-operation discards all entries on that edge.
- Earliest commit: issue at edge t, CDB at cycle t+1 (edge t+2 sets ready), commit in cycle t+2.
- A CDB result is visible to queries in the same cycle (bypass) and is committable from the next cycle.
- rdy_in low freezes all registers. Combinational commit outputs and store_commit are 0 while rdy_in is low.
- A mispredict flush takes 1 cycle. The first new issue is accepted in the cycle after clear_flag.
- Pointer wrap: tail at 2^ROB_WIDTH_BIT-1 wraps to 0. Full means count = depth, with head == tail.

## Test plan
- Issue REG rd=5 into the empty ROB -> new_reg_id=5, new_ROB_id=0. ALU CDB id0 val=0x1234 next cycle -> write_reg_id=5, write_ROB_id=0, write_val=0x1234 one cycle later.
- Issue 8 REGs with depth 8 -> rob_full=1 after the 8th. Complete them out of order (7..0) -> commits occur in order 0..7. Issue a 9th after the first commit -> tail wraps to id 0.
- Query rs1_id=2 while ALU CDB writes id2 val=7 in the same cycle -> rs1_ready=1, rs1_val=7.
- BRANCH pred_taken=0, actual value[0]=1, alt_pc=0x100, with 3 younger entries -> clear_flag=1 and redirect_pc=0x100 for one cycle. Younger entries are never committed; count=0 afterwards.
- STORE at head with ready -> store_commit=1, store_commit_id=head, write_reg_id=0. Hold rdy_in=0 with ready head -> no commit and no pointer change until rdy_in returns.
- Assert rst_in with 4 busy entries -> all outputs at reset values the next cycle; rob_full=0.

Source files
------------

// File: rtl/rob_commit_if.sv
// ============================================================================
// Module      : rob_commit_if
// Description : Issue, result-bus, query, commit and flush signals of the ROB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface rob_commit_if #(
    parameter int ROB_WIDTH_BIT = 3
);
    logic                     rdy_in;

    logic                     issue_valid;
    logic [1:0]               issue_type;
    logic [4:0]               issue_rd;
    logic                     issue_pred_taken;
    logic [31:0]              issue_alt_pc;
    logic                     rob_full;
    logic [ROB_WIDTH_BIT-1:0] issue_rob_id;
    logic [4:0]               new_reg_id;
    logic [ROB_WIDTH_BIT-1:0] new_ROB_id;

    logic                     alu_cdb_valid;
    logic [ROB_WIDTH_BIT-1:0] alu_cdb_id;
    logic [31:0]              alu_cdb_val;
    logic                     lsb_cdb_valid;
    logic [ROB_WIDTH_BIT-1:0] lsb_cdb_id;
    logic [31:0]              lsb_cdb_val;

    logic [ROB_WIDTH_BIT-1:0] rs1_id;
    logic [ROB_WIDTH_BIT-1:0] rs2_id;
    logic                     rs1_ready;
    logic                     rs2_ready;
    logic [31:0]              rs1_val;
    logic [31:0]              rs2_val;

    logic [4:0]               write_reg_id;
    logic [ROB_WIDTH_BIT-1:0] write_ROB_id;
    logic [31:0]              write_val;
    logic                     store_commit;
    logic [ROB_WIDTH_BIT-1:0] store_commit_id;
    logic                     clear_flag;
    logic [31:0]              redirect_pc;
    logic                     halt;

    // Surrounding core: decoder, result buses, regfile, LSB, fetch
    modport master (
        output rdy_in, issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
        output alu_cdb_valid, alu_cdb_id, alu_cdb_val,
        output lsb_cdb_valid, lsb_cdb_id, lsb_cdb_val,
        output rs1_id, rs2_id,
        input  rob_full, issue_rob_id, new_reg_id, new_ROB_id,
        input  rs1_ready, rs2_ready, rs1_val, rs2_val,
        input  write_reg_id, write_ROB_id, write_val,
        input  store_commit, store_commit_id, clear_flag, redirect_pc, halt
    );

    modport slave (
        input  rdy_in, issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
        input  alu_cdb_valid, alu_cdb_id, alu_cdb_val,
        input  lsb_cdb_valid, lsb_cdb_id, lsb_cdb_val,
        input  rs1_id, rs2_id,
        output rob_full, issue_rob_id, new_reg_id, new_ROB_id,
        output rs1_ready, rs2_ready, rs1_val, rs2_val,
        output write_reg_id, write_ROB_id, write_val,
        output store_commit, store_commit_id, clear_flag, redirect_pc, halt
    );
endinterface

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ============================================================================
// Module      : rob_commit_unit
// Description : Reorder buffer: allocation, CDB capture, operand queries,
//               in-order retirement and branch-mispredict flush.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rob_commit_unit #(
    parameter int ROB_WIDTH_BIT = 3
) (
    input  wire logic    clk_in,
    input  wire logic    rst_in,
    rob_commit_if.slave  bus
);

    localparam int DEPTH = 1 << ROB_WIDTH_BIT;

    localparam logic [1:0] c_type_reg    = 2'd0;
    localparam logic [1:0] c_type_store  = 2'd1;
    localparam logic [1:0] c_type_branch = 2'd2;
    localparam logic [1:0] c_type_exit   = 2'd3;

    localparam logic [ROB_WIDTH_BIT:0]   c_full_count = (ROB_WIDTH_BIT + 1)'(DEPTH);
    localparam logic [ROB_WIDTH_BIT:0]   c_count_one  = (ROB_WIDTH_BIT + 1)'(1);
    localparam logic [ROB_WIDTH_BIT-1:0] c_ptr_one    = ROB_WIDTH_BIT'(1);

    logic [DEPTH-1:0]         r_busy;
    logic [DEPTH-1:0]         r_ready;
    logic [DEPTH-1:0]         r_pred;
    logic [1:0]               r_type   [DEPTH];
    logic [4:0]               r_rd     [DEPTH];
    logic [31:0]              r_value  [DEPTH];
    logic [31:0]              r_alt_pc [DEPTH];

    logic [ROB_WIDTH_BIT-1:0] r_head;
    logic [ROB_WIDTH_BIT-1:0] r_tail;
    logic [ROB_WIDTH_BIT:0]   r_count;
    logic                     r_clear_flag;
    logic [31:0]              r_redirect_pc;
    logic                     r_halt;

    logic                     w_full;
    logic                     w_accept;
    logic                     w_commit;
    logic                     w_commit_reg;
    logic                     w_commit_store;
    logic                     w_commit_exit;
    logic                     w_mispredict;
    logic                     w_cdb_en;
    logic [1:0]               w_head_type;

    assign w_full      = (r_count == c_full_count);
    assign w_head_type = r_type[r_head];

    assign w_accept = bus.issue_valid && !w_full && !r_clear_flag && bus.rdy_in && !r_halt;

    assign w_commit       = r_busy[r_head] && r_ready[r_head] && bus.rdy_in
                            && !r_clear_flag && !r_halt;
    assign w_commit_reg   = w_commit && (w_head_type == c_type_reg);
    assign w_commit_store = w_commit && (w_head_type == c_type_store);
    assign w_commit_exit  = w_commit && (w_head_type == c_type_exit);
    assign w_mispredict   = w_commit && (w_head_type == c_type_branch)
                            && (r_value[r_head][0] != r_pred[r_head]);

    assign w_cdb_en = bus.rdy_in && !r_clear_flag;

    assign bus.rob_full     = w_full;
    assign bus.issue_rob_id = r_tail;
    assign bus.new_ROB_id   = r_tail;
    assign bus.new_reg_id   = (w_accept && bus.issue_type == c_type_reg) ? bus.issue_rd : 5'd0;

    assign bus.write_reg_id    = w_commit_reg ? r_rd[r_head]    : 5'd0;
    assign bus.write_ROB_id    = w_commit_reg ? r_head          : '0;
    assign bus.write_val       = w_commit_reg ? r_value[r_head] : 32'd0;
    assign bus.store_commit    = w_commit_store;
    assign bus.store_commit_id = w_commit_store ? r_head : '0;

    assign bus.clear_flag  = r_clear_flag;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.halt        = r_halt;

    // Operand queries: a same-cycle broadcast wins over the stored entry, ALU first
    always_comb begin
        bus.rs1_ready = r_ready[bus.rs1_id];
        bus.rs1_val   = r_value[bus.rs1_id];
        if (bus.alu_cdb_valid && bus.alu_cdb_id == bus.rs1_id) begin
            bus.rs1_ready = 1'b1;
            bus.rs1_val   = bus.alu_cdb_val;
        end else if (bus.lsb_cdb_valid && bus.lsb_cdb_id == bus.rs1_id) begin
            bus.rs1_ready = 1'b1;
            bus.rs1_val   = bus.lsb_cdb_val;
        end
    end

    always_comb begin
        bus.rs2_ready = r_ready[bus.rs2_id];
        bus.rs2_val   = r_value[bus.rs2_id];
        if (bus.alu_cdb_valid && bus.alu_cdb_id == bus.rs2_id) begin
            bus.rs2_ready = 1'b1;
            bus.rs2_val   = bus.alu_cdb_val;
        end else if (bus.lsb_cdb_valid && bus.lsb_cdb_id == bus.rs2_id) begin
            bus.rs2_ready = 1'b1;
            bus.rs2_val   = bus.lsb_cdb_val;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy        <= '0;
            r_ready       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_clear_flag  <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_halt        <= 1'b0;
        end else if (bus.rdy_in) begin
            r_clear_flag  <= w_mispredict;
            r_redirect_pc <= w_mispredict ? r_alt_pc[r_head] : 32'd0;
            if (w_commit_exit) begin
                r_halt <= 1'b1;
            end

            if (w_mispredict) begin
                // Everything younger than the branch is wrong-path work
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_cdb_en && bus.alu_cdb_valid) begin
                    r_ready[bus.alu_cdb_id] <= 1'b1;
                    r_value[bus.alu_cdb_id] <= bus.alu_cdb_val;
                end
                if (w_cdb_en && bus.lsb_cdb_valid) begin
                    r_ready[bus.lsb_cdb_id] <= 1'b1;
                    r_value[bus.lsb_cdb_id] <= bus.lsb_cdb_val;
                end

                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + c_ptr_one;
                end

                // Allocation is placed last so a stale broadcast cannot mark a fresh entry ready
                if (w_accept) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_ready[r_tail]  <= 1'b0;
                    r_type[r_tail]   <= bus.issue_type;
                    r_rd[r_tail]     <= bus.issue_rd;
                    r_pred[r_tail]   <= bus.issue_pred_taken;
                    r_alt_pc[r_tail] <= bus.issue_alt_pc;
                    r_tail           <= r_tail + c_ptr_one;
                end

                case ({w_accept, w_commit})
                    2'b10:   r_count <= r_count + c_count_one;
                    2'b01:   r_count <= r_count - c_count_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// Module      : tb_rob_commit_unit
// Description : Directed self-checking bench for rob_commit_unit (depth 8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_unit;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   errors = 0;
    int   checks = 0;

    localparam int T_REG = 0, T_STORE = 1, T_BRANCH = 2, T_EXIT = 3;

    always #5 clk_in = ~clk_in;

    rob_commit_if #(.ROB_WIDTH_BIT(3)) bus ();

    rob_commit_unit #(.ROB_WIDTH_BIT(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid      = 1'b0;
        bus.issue_type       = 2'd0;
        bus.issue_rd         = 5'd0;
        bus.issue_pred_taken = 1'b0;
        bus.issue_alt_pc     = 32'd0;
        bus.alu_cdb_valid    = 1'b0;
        bus.alu_cdb_id       = 3'd0;
        bus.alu_cdb_val      = 32'd0;
        bus.lsb_cdb_valid    = 1'b0;
        bus.lsb_cdb_id       = 3'd0;
        bus.lsb_cdb_val      = 32'd0;
        bus.rs1_id           = 3'd0;
        bus.rs2_id           = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic iss(input int t, input int rd, input int pred, input logic [31:0] alt);
        bus.issue_valid      = 1'b1;
        bus.issue_type       = 2'(t);
        bus.issue_rd         = 5'(rd);
        bus.issue_pred_taken = 1'(pred);
        bus.issue_alt_pc     = alt;
    endtask

    task automatic alu(input int id, input logic [31:0] val);
        bus.alu_cdb_valid = 1'b1;
        bus.alu_cdb_id    = 3'(id);
        bus.alu_cdb_val   = val;
    endtask

    task automatic lsb(input int id, input logic [31:0] val);
        bus.lsb_cdb_valid = 1'b1;
        bus.lsb_cdb_id    = 3'(id);
        bus.lsb_cdb_val   = val;
    endtask

    initial begin
        bus.rdy_in = 1'b1;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        settle();
        chk("rst_rob_full",    32'(bus.rob_full),     0);
        chk("rst_clear_flag",  32'(bus.clear_flag),   0);
        chk("rst_redirect_pc", bus.redirect_pc,       0);
        chk("rst_halt",        32'(bus.halt),         0);
        chk("rst_store",       32'(bus.store_commit), 0);
        chk("rst_write_reg",   32'(bus.write_reg_id), 0);

        // Single REG: issue, ALU result next cycle, commit the cycle after
        iss(T_REG, 5, 0, 0);
        settle();
        chk("t1_new_reg", 32'(bus.new_reg_id), 5);
        chk("t1_new_rob", 32'(bus.new_ROB_id), 0);
        tick();
        alu(0, 32'h1234);
        bus.rs1_id = 3'd0;
        settle();
        chk("t1_bypass_rdy", 32'(bus.rs1_ready),    1);
        chk("t1_bypass_val", bus.rs1_val,           32'h1234);
        chk("t1_no_early",   32'(bus.write_reg_id), 0);
        tick();
        settle();
        chk("t1_wr_reg", 32'(bus.write_reg_id), 5);
        chk("t1_wr_rob", 32'(bus.write_ROB_id), 0);
        chk("t1_wr_val", bus.write_val,         32'h1234);
        tick();
        settle();
        chk("t1_once", 32'(bus.write_reg_id), 0);

        // Fill to depth, complete in reverse, retire in order, wrap
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iss(T_REG, 10 + i, 0, 0);
            settle();
            chk("t2_fill_id",   32'(bus.new_ROB_id), 32'(i));
            chk("t2_fill_full", 32'(bus.rob_full),   0);
            tick();
        end
        settle();
        chk("t2_full", 32'(bus.rob_full), 1);
        for (int j = 0; j < 8; j++) begin
            alu(7 - j, 32'(32'hA0 + 7 - j));
            if (j == 0) iss(T_REG, 20, 0, 0);
            settle();
            chk("t2_wait_commit", 32'(bus.write_reg_id), 0);
            if (j == 0) chk("t2_full_reject", 32'(bus.new_reg_id), 0);
            tick();
        end
        iss(T_REG, 20, 0, 0);
        settle();
        chk("t2_k0_reg",     32'(bus.write_reg_id), 10);
        chk("t2_k0_rob",     32'(bus.write_ROB_id), 0);
        chk("t2_k0_val",     bus.write_val,         32'hA0);
        chk("t2_k0_full",    32'(bus.rob_full),     1);
        chk("t2_k0_noissue", 32'(bus.new_reg_id),   0);
        tick();
        iss(T_REG, 20, 0, 0);
        settle();
        chk("t2_k1_full", 32'(bus.rob_full),     0);
        chk("t2_wrap_rd", 32'(bus.new_reg_id),   20);
        chk("t2_wrap_id", 32'(bus.new_ROB_id),   0);
        chk("t2_k1_reg",  32'(bus.write_reg_id), 11);
        chk("t2_k1_rob",  32'(bus.write_ROB_id), 1);
        tick();
        for (int k = 2; k < 8; k++) begin
            settle();
            chk("t2_order_reg", 32'(bus.write_reg_id), 32'(10 + k));
            chk("t2_order_rob", 32'(bus.write_ROB_id), 32'(k));
            chk("t2_order_val", bus.write_val,         32'(32'hA0 + k));
            tick();
        end
        alu(0, 32'h55);
        settle();
        chk("t2_k8_wait", 32'(bus.write_reg_id), 0);
        tick();
        settle();
        chk("t2_k9_reg", 32'(bus.write_reg_id), 20);
        chk("t2_k9_rob", 32'(bus.write_ROB_id), 0);
        chk("t2_k9_val", bus.write_val,         32'h55);
        tick();

        // Query bypass on both buses (entries 1 and 2)
        iss(T_REG, 1, 0, 0);
        tick();
        iss(T_REG, 2, 0, 0);
        bus.rs1_id = 3'd1;
        settle();
        chk("t3_not_ready", 32'(bus.rs1_ready), 0);
        tick();
        bus.rs1_id = 3'd2;
        bus.rs2_id = 3'd1;
        alu(2, 32'd7);
        lsb(1, 32'd9);
        settle();
        chk("t3_rs1_rdy", 32'(bus.rs1_ready), 1);
        chk("t3_rs1_val", bus.rs1_val,        7);
        chk("t3_rs2_rdy", 32'(bus.rs2_ready), 1);
        chk("t3_rs2_val", bus.rs2_val,        9);
        tick();
        bus.rs1_id = 3'd2;
        settle();
        chk("t3_stored_rdy", 32'(bus.rs1_ready),    1);
        chk("t3_stored_val", bus.rs1_val,           7);
        chk("t3_c1_reg",     32'(bus.write_reg_id), 1);
        chk("t3_c1_val",     bus.write_val,         9);
        tick();
        settle();
        chk("t3_c2_reg", 32'(bus.write_reg_id), 2);
        chk("t3_c2_rob", 32'(bus.write_ROB_id), 2);
        tick();

        // Mispredicted branch at id3 with three younger entries
        iss(T_BRANCH, 0, 0, 32'h100);
        settle();
        chk("t4_br_id", 32'(bus.new_ROB_id), 3);
        tick();
        iss(T_REG, 21, 0, 0);
        tick();
        iss(T_REG, 22, 0, 0);
        tick();
        iss(T_REG, 23, 0, 0);
        alu(3, 32'd1);
        tick();
        lsb(4, 32'h44);
        settle();
        chk("t4_br_noreg",  32'(bus.write_reg_id), 0);
        chk("t4_pre_clear", 32'(bus.clear_flag),   0);
        tick();
        iss(T_REG, 9, 0, 0);
        alu(0, 32'h77);
        settle();
        chk("t4_clear",       32'(bus.clear_flag),   1);
        chk("t4_redirect",    bus.redirect_pc,       32'h100);
        chk("t4_issue_block", 32'(bus.new_reg_id),   0);
        chk("t4_no_commit",   32'(bus.write_reg_id), 0);
        tick();
        bus.rs1_id = 3'd0;
        iss(T_REG, 9, 0, 0);
        settle();
        chk("t4_clear_once", 32'(bus.clear_flag), 0);
        chk("t4_cdb_ignored", 32'(bus.rs1_ready), 0);
        chk("t4_reissue_rd", 32'(bus.new_reg_id), 9);
        chk("t4_reissue_id", 32'(bus.new_ROB_id), 0);
        tick();
        alu(0, 32'h99);
        settle();
        chk("t4_young_gone", 32'(bus.write_reg_id), 0);
        tick();
        settle();
        chk("t4_c_reg", 32'(bus.write_reg_id), 9);
        chk("t4_c_val", bus.write_val,         32'h99);
        tick();

        // STORE retirement with rdy_in stall (store lands at id1)
        iss(T_STORE, 0, 0, 0);
        settle();
        chk("t5_st_noreg", 32'(bus.new_reg_id), 0);
        chk("t5_st_id",    32'(bus.new_ROB_id), 1);
        tick();
        lsb(1, 32'd0);
        tick();
        bus.rdy_in = 1'b0;
        iss(T_REG, 3, 0, 0);
        settle();
        chk("t5_stall_store", 32'(bus.store_commit), 0);
        chk("t5_stall_issue", 32'(bus.new_reg_id),   0);
        tick();
        tick();
        settle();
        chk("t5_stall_tail",   32'(bus.issue_rob_id), 2);
        chk("t5_stall_store2", 32'(bus.store_commit), 0);
        bus.rdy_in = 1'b1;
        settle();
        chk("t5_store",    32'(bus.store_commit),    1);
        chk("t5_store_id", 32'(bus.store_commit_id), 1);
        chk("t5_st_wr",    32'(bus.write_reg_id),    0);
        tick();
        settle();
        chk("t5_store_once", 32'(bus.store_commit), 0);

        // Reset with four busy entries, head ready
        for (int i = 0; i < 4; i++) begin
            iss(T_REG, 24 + i, 0, 0);
            if (i == 3) alu(2, 32'd1);
            tick();
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        settle();
        chk("t6_full",     32'(bus.rob_full),     0);
        chk("t6_wr",       32'(bus.write_reg_id), 0);
        chk("t6_store",    32'(bus.store_commit), 0);
        chk("t6_clear",    32'(bus.clear_flag),   0);
        chk("t6_tail",     32'(bus.issue_rob_id), 0);

        // EXIT retires and halts
        iss(T_EXIT, 0, 0, 0);
        settle();
        chk("t7_exit_noreg", 32'(bus.new_reg_id), 0);
        tick();
        alu(0, 32'd0);
        tick();
        settle();
        chk("t7_pre_halt", 32'(bus.halt), 0);
        tick();
        iss(T_REG, 4, 0, 0);
        settle();
        chk("t7_halt",       32'(bus.halt),       1);
        chk("t7_halt_issue", 32'(bus.new_reg_id), 0);
        tick();
        settle();
        chk("t7_halt_sticky", 32'(bus.halt), 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        settle();
        chk("t7_halt_reset", 32'(bus.halt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
